// File: rtl/uart_tx_queue.sv
// uart_tx_queue: memory-mapped byte FIFO that drains into uarttx one byte at a time.
// Word map: 0 DATA (push), 1 STATUS (read), 2 CTRL (flush / clear overflow), 3 reserved.
module uart_tx_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       wen,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    input  logic       ren,
    input  logic [1:0] raddr,
    output logic [7:0] rdata,
    output logic [7:0] charout,
    output logic       txen,
    input  logic       uartbusy,
    output logic       full,
    output logic       empty
);

    // count needs one extra bit so that DEPTH itself is representable
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitHi,
        StWaitLo
    } state_e;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          overflow;
    state_e        state;
    logic [1:0]    wait_cnt;

    logic       data_wr;
    logic       ctrl_wr;
    logic       flush;
    logic       clr_ovf;
    logic       pop;
    logic       push_ok;
    logic [4:0] count_sat;
    logic [7:0] status;

    // Bus decode and push acceptance; a pop in the same cycle frees a slot at full
    always_comb begin
        data_wr = wen && (waddr == 2'd0);
        ctrl_wr = wen && (waddr == 2'd2);
        flush   = ctrl_wr && wdata[0];
        clr_ovf = ctrl_wr && wdata[1];
        pop     = (state == StLoad);
        full    = (count == DEPTH_CNT);
        push_ok = data_wr && (!full || pop) && !flush;
        empty   = (count == '0) && (state == StIdle) && !uartbusy;
    end

    // STATUS word, count saturated at 31 so large DEPTH still fits in five bits
    always_comb begin
        if (32'(count) > 32'd31) begin
            count_sat = 5'd31;
        end else begin
            count_sat = 5'(count);
        end
        status = {overflow, full, empty, count_sat};
    end

    // FIFO storage; contents need no reset since count guards every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers and occupancy; flush overrides any same-cycle push or pop
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: set by a dropped push, cleared only by CTRL bit1
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow <= 1'b0;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end else if (data_wr && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // Drain FSM; charout and txen are registered so both are valid during LOAD
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= StIdle;
            txen     <= 1'b0;
            charout  <= 8'h00;
            wait_cnt <= 2'd0;
        end else begin
            txen <= 1'b0;
            unique case (state)
                StIdle: begin
                    // A flush in this cycle empties the queue, so do not start
                    if ((count != '0) && !uartbusy && !flush) begin
                        state   <= StLoad;
                        txen    <= 1'b1;
                        charout <= mem[rptr];
                    end
                end
                StLoad: begin
                    state    <= StWaitHi;
                    wait_cnt <= 2'd0;
                end
                StWaitHi: begin
                    if (uartbusy) begin
                        state <= StWaitLo;
                    end else if (wait_cnt == 2'd3) begin
                        // uarttx never went busy; treat the byte as sent
                        state <= StIdle;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                StWaitLo: begin
                    if (!uartbusy) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Registered read port; holds its value between reads
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rdata <= 8'h00;
        end else if (ren) begin
            rdata <= (raddr == 2'd1) ? status : 8'h00;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: register-map vectors, directed drain/overflow/flush/reset
// sequences and randomized traffic against a queue-based reference model.
module tb_uart_tx_queue;

    localparam int DEPTH = 16;

    logic       clk;
    logic       n_rst;
    logic       wen;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic       ren;
    logic [1:0] raddr;
    logic [7:0] rdata;
    logic [7:0] charout;
    logic       txen;
    logic       uartbusy;
    logic       full;
    logic       empty;

    uart_tx_queue #(
        .DEPTH(16),
        .AW   (4)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .ren     (ren),
        .raddr   (raddr),
        .rdata   (rdata),
        .charout (charout),
        .txen    (txen),
        .uartbusy(uartbusy),
        .full    (full),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uarttx stand-in: goes busy for busy_len cycles after each txen, logs bytes
    int         busy_cnt = 0;
    int         busy_len;
    int         busy_viol = 0;
    logic       busy_force;
    logic [7:0] tx_log[$];

    assign uartbusy = n_rst && (busy_force || (busy_cnt != 0));

    always @(negedge clk) begin
        if (!n_rst) begin
            busy_cnt = 0;
        end else if (txen) begin
            if (uartbusy) busy_viol++;
            tx_log.push_back(charout);
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the falling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr_now(input logic [1:0] a, input logic [7:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        wen   = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        tick();
        wr_now(a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        tick();
        ren   = 1'b1;
        raddr = a;
        tick();
        ren   = 1'b0;
        d     = rdata;
    endtask

    task automatic wait_txen(input int maxc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (txen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(input int n_log, input int maxc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (tx_log.size() == n_log && empty) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct packed {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[12];
    logic [7:0] rd;
    logic       ok;
    int         base;
    logic [7:0] exp_c[18];
    logic [7:0] exp_q[$];

    initial begin
        n_rst      = 1'b0;
        wen        = 1'b0;
        waddr      = 2'd0;
        wdata      = 8'h00;
        ren        = 1'b0;
        raddr      = 2'd0;
        busy_force = 1'b0;
        busy_len   = 0;

        // Register map with uarttx held busy so nothing drains
        vecs[0]  = '{1'b0, 2'd0, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 2'd2, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 2'd3, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 2'd0, 8'h11, 8'h00};
        vecs[4]  = '{1'b0, 2'd1, 8'h00, 8'h01};
        vecs[5]  = '{1'b1, 2'd3, 8'hFF, 8'h00};
        vecs[6]  = '{1'b0, 2'd1, 8'h00, 8'h01};
        vecs[7]  = '{1'b1, 2'd0, 8'h22, 8'h00};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 2'd1, 8'h00, 8'h02};
        vecs[10] = '{1'b1, 2'd2, 8'h01, 8'h00};
        vecs[11] = '{1'b0, 2'd1, 8'h00, 8'h00};

        // Reset state
        repeat (2) tick();
        check("rst_rdata", rdata, 8'h00);
        check("rst_charout", charout, 8'h00);
        check("rst_txen", {7'd0, txen}, 8'h00);
        check("rst_full", {7'd0, full}, 8'h00);
        check("rst_empty", {7'd0, empty}, 8'h01);
        n_rst = 1'b1;
        bus_read(2'd1, rd);
        check("status_after_reset", rd, 8'h20);
        repeat (20) tick();
        check("no_txen_idle", 8'(tx_log.size()), 8'd0);

        busy_force = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d", i), rd, vecs[i].exp);
            end
        end
        busy_force = 1'b0;
        repeat (10) tick();
        check("flushed_no_tx", 8'(tx_log.size()), 8'd0);

        // Three bytes, uarttx busy for 10 cycles each
        busy_len = 10;
        base     = tx_log.size();
        bus_write(2'd0, 8'h41);
        bus_write(2'd0, 8'h42);
        bus_write(2'd0, 8'h43);
        wait_drain(base + 3, 300, ok);
        check("drain3_done", {7'd0, ok}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            if (base + i < tx_log.size())
                check($sformatf("drain3_byte%0d", i), tx_log[base+i], 8'h41 + 8'(i));
            else
                check($sformatf("drain3_byte%0d", i), 8'hxx, 8'h41 + 8'(i));
        end
        check("drain3_empty", {7'd0, empty}, 8'h01);

        // Fill to DEPTH behind one in-flight byte, then overflow
        busy_len = 0;
        base     = tx_log.size();
        bus_write(2'd0, 8'h00);
        wait_txen(20, ok);
        check("first_pop", {7'd0, ok}, 8'h01);
        busy_force = 1'b1;
        for (int i = 1; i <= 16; i++) bus_write(2'd0, 8'(i));
        check("full_flag", {7'd0, full}, 8'h01);
        bus_read(2'd1, rd);
        check("status_full", rd, 8'h50);
        bus_write(2'd0, 8'hEE);
        check("rdata_hold", rdata, 8'h50);
        bus_read(2'd1, rd);
        check("status_overflow", rd, 8'hD0);
        bus_write(2'd2, 8'h02);
        bus_read(2'd1, rd);
        check("status_ovf_cleared", rd, 8'h50);

        // Push in the LOAD cycle while full
        busy_len   = 3;
        busy_force = 1'b0;
        wait_txen(20, ok);
        check("load_at_full", {7'd0, ok}, 8'h01);
        busy_force = 1'b1;
        wr_now(2'd0, 8'hAA);
        bus_read(2'd1, rd);
        check("status_push_pop", rd, 8'h50);
        busy_force = 1'b0;
        for (int i = 0; i < 17; i++) exp_c[i] = 8'(i);
        exp_c[17] = 8'hAA;
        wait_drain(base + 18, 600, ok);
        check("wrap_drain_done", {7'd0, ok}, 8'h01);
        for (int i = 0; i < 18; i++) begin
            if (base + i < tx_log.size())
                check($sformatf("wrap_byte%0d", i), tx_log[base+i], exp_c[i]);
            else
                check($sformatf("wrap_byte%0d", i), 8'hxx, exp_c[i]);
        end

        // Flush while the first of five bytes is on the wire
        busy_len = 30;
        base     = tx_log.size();
        for (int i = 0; i < 5; i++) bus_write(2'd0, 8'h51 + 8'(i));
        bus_write(2'd2, 8'h01);
        bus_read(2'd1, rd);
        check("status_after_flush", rd, 8'h00);
        wait_drain(base + 1, 100, ok);
        check("flush_cur_done", {7'd0, ok}, 8'h01);
        repeat (10) tick();
        check("flush_one_tx", 8'(tx_log.size() - base), 8'd1);
        if (tx_log.size() > base) check("flush_byte", tx_log[base], 8'h51);
        bus_read(2'd1, rd);
        check("status_flushed_idle", rd, 8'h20);
        bus_write(2'd0, 8'h61);
        wait_drain(base + 2, 100, ok);
        check("post_flush_done", {7'd0, ok}, 8'h01);
        if (tx_log.size() > base + 1) check("post_flush_byte", tx_log[base+1], 8'h61);

        // Asynchronous reset mid-queue
        busy_len = 10;
        for (int i = 0; i < 4; i++) bus_write(2'd0, 8'h71 + 8'(i));
        repeat (2) tick();
        bus_read(2'd1, rd);
        #3;
        n_rst = 1'b0;
        #1;
        check("arst_rdata", rdata, 8'h00);
        check("arst_charout", charout, 8'h00);
        check("arst_txen", {7'd0, txen}, 8'h00);
        check("arst_full", {7'd0, full}, 8'h00);
        check("arst_empty", {7'd0, empty}, 8'h01);
        repeat (2) tick();
        n_rst = 1'b1;
        base  = tx_log.size();
        repeat (30) tick();
        check("no_tx_after_reset", 8'(tx_log.size() - base), 8'd0);
        bus_write(2'd0, 8'h7A);
        wait_drain(base + 1, 100, ok);
        check("post_reset_done", {7'd0, ok}, 8'h01);
        if (tx_log.size() > base) check("post_reset_byte", tx_log[base], 8'h7A);

        // Randomized traffic against a queue model
        for (int r = 0; r < 10; r++) begin
            int   acc;
            int   nwr;
            logic ovf;
            logic [7:0] d;
            busy_len = $urandom_range(0, 12);
            nwr      = $urandom_range(1, 24);
            base     = tx_log.size();
            acc      = 0;
            ovf      = 1'b0;
            exp_q.delete();
            for (int k = 0; k < nwr; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                tick();
                d = 8'($urandom);
                // Occupancy as seen at this edge, net of any pop already handed over
                if (acc - (tx_log.size() - base) < DEPTH) begin
                    acc++;
                    exp_q.push_back(d);
                end else begin
                    ovf = 1'b1;
                end
                wr_now(2'd0, d);
            end
            wait_drain(base + acc, 3000, ok);
            check($sformatf("rnd%0d_drain", r), {7'd0, ok}, 8'h01);
            check($sformatf("rnd%0d_count", r), 8'(tx_log.size() - base), 8'(acc));
            for (int k = 0; k < acc && base + k < tx_log.size(); k++)
                check($sformatf("rnd%0d_byte%0d", r, k), tx_log[base+k], exp_q[k]);
            bus_read(2'd1, rd);
            check($sformatf("rnd%0d_status", r), rd, ovf ? 8'hA0 : 8'h20);
            bus_write(2'd2, ($urandom_range(0, 1) != 0) ? 8'h03 : 8'h02);
            bus_read(2'd1, rd);
            check($sformatf("rnd%0d_cleared", r), rd, 8'h20);
        end

        check("busy_low_at_txen", 8'(busy_viol), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
